// File: rtl/sigma_point_gen.sv
// sigma_point_gen: scales a packed Cholesky factor by GAMMA and streams
// the 2N+1 sigma points (x, x+G*L(:,j), x-G*L(:,j)) over a valid/ready port.
module sigma_point_gen #(
   parameter int           N     = 5,
   parameter int           W     = 32,
   parameter int           FRAC  = 16,
   parameter logic [W-1:0] GAMMA = 32'h00023C70
) (
   input  logic                   clk,
   input  logic                   clk_en,
   input  logic                   rst,
   input  logic [W*N*(N+1)/2-1:0] L,
   input  logic                   L_valid,
   input  logic [W*N-1:0]         x_mean,
   output logic                   busy,
   output logic [W*N-1:0]         chi,
   output logic [3:0]             chi_idx,
   output logic                   chi_valid,
   input  logic                   chi_ready
);

   localparam int              NL    = N*(N+1)/2;
   localparam int              KW    = $clog2(NL);
   localparam logic [KW-1:0]   KLAST = KW'(NL-1);
   localparam logic [3:0]      NI    = 4'(N);
   localparam logic [3:0]      LAST  = 4'(2*N);
   localparam logic [W-1:0]    MAXV  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]    MINV  = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCALE,
      S_EMIT
   } state_t;

   state_t           r_state;
   state_t           w_state_n;

   logic [W-1:0]     r_l [NL];
   logic [W-1:0]     r_s [NL];
   logic [W-1:0]     r_x [N];
   logic [KW-1:0]    r_k;
   logic             r_busy;
   logic [W*N-1:0]   r_chi;
   logic [3:0]       r_chi_idx;
   logic             r_chi_valid;

   logic             w_accept;
   logic             w_scale;
   logic             w_load;
   logic             w_done;

   logic [W-1:0]     w_lk;
   logic signed [2*W-1:0] w_p;
   logic signed [2*W-1:0] w_q;
   logic             w_fits;
   logic [W-1:0]     w_sk;

   logic [3:0]       w_pidx;
   logic             w_mod;
   logic             w_sub;
   logic [3:0]       w_colx;
   logic [KW-1:0]    w_col;
   logic [W*N-1:0]   w_pt;

   // W-bit signed add or subtract, clamped to the representable range
   function automatic logic [W-1:0] sat_add(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         sub
   );
      logic signed [W:0] t;
      logic [W-1:0]      r;
      if (sub)
         t = $signed({a[W-1], a}) - $signed({b[W-1], b});
      else
         t = $signed({a[W-1], a}) + $signed({b[W-1], b});
      if (t[W] == t[W-1])
         r = t[W-1:0];
      else if (t[W])
         r = MINV;
      else
         r = MAXV;
      return r;
   endfunction

   // Single shared multiplier: one packed entry per SCALE cycle
   assign w_lk   = r_l[r_k];
   assign w_p    = $signed({{W{w_lk[W-1]}}, w_lk})
                 * $signed({{W{GAMMA[W-1]}}, GAMMA});
   assign w_q    = w_p >>> FRAC;
   assign w_fits = (w_q[2*W-1:W-1] == '0) || (w_q[2*W-1:W-1] == '1);
   assign w_sk   = w_fits ? w_q[W-1:0] : (w_q[2*W-1] ? MINV : MAXV);

   // Index to present next: current one until it is consumed, then +1
   assign w_pidx = r_chi_valid ? (r_chi_idx + 4'd1) : r_chi_idx;
   assign w_mod  = (w_pidx != 4'd0);
   assign w_sub  = (w_pidx > NI);
   assign w_colx = w_sub ? (w_pidx - NI - 4'd1) : (w_pidx - 4'd1);
   assign w_col  = KW'(w_colx);

   // Build the sigma point for w_pidx; above-diagonal entries are zero
   always_comb begin
      w_pt = '0;
      for (int i = 0; i < N; i++) begin
         if (w_mod && (KW'(i) >= w_col))
            w_pt[W*i +: W] = sat_add(r_x[i],
                                     r_s[KW'(i*(i+1)/2) + w_col],
                                     w_sub);
         else
            w_pt[W*i +: W] = r_x[i];
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else if (clk_en)
         r_state <= w_state_n;
   end

   // FSM next state and datapath strobes
   always_comb begin
      w_state_n = r_state;
      w_accept  = 1'b0;
      w_scale   = 1'b0;
      w_load    = 1'b0;
      w_done    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (L_valid) begin
               w_accept  = 1'b1;
               w_state_n = S_SCALE;
            end
         end
         S_SCALE: begin
            w_scale = 1'b1;
            if (r_k == KLAST)
               w_state_n = S_EMIT;
         end
         S_EMIT: begin
            if (!r_chi_valid) begin
               w_load = 1'b1;
            end else if (chi_ready) begin
               if (r_chi_idx == LAST) begin
                  w_done    = 1'b1;
                  w_state_n = S_IDLE;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // Operand capture and scaled-factor storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NL; k++) begin
            r_l[k] <= '0;
            r_s[k] <= '0;
         end
         for (int i = 0; i < N; i++)
            r_x[i] <= '0;
         r_k <= '0;
      end else if (clk_en) begin
         if (w_accept) begin
            for (int k = 0; k < NL; k++)
               r_l[k] <= L[W*k +: W];
            for (int i = 0; i < N; i++)
               r_x[i] <= x_mean[W*i +: W];
            r_k <= '0;
         end
         if (w_scale) begin
            r_s[r_k] <= w_sk;
            r_k      <= r_k + KW'(1);
         end
      end
   end

   // Output register: busy flag and the presented sigma point
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy      <= 1'b0;
         r_chi       <= '0;
         r_chi_idx   <= '0;
         r_chi_valid <= 1'b0;
      end else if (clk_en) begin
         if (w_accept) begin
            r_busy    <= 1'b1;
            r_chi_idx <= '0;
         end
         if (w_load) begin
            r_chi       <= w_pt;
            r_chi_idx   <= w_pidx;
            r_chi_valid <= 1'b1;
         end
         if (w_done) begin
            r_chi_valid <= 1'b0;
            r_busy      <= 1'b0;
         end
      end
   end

   assign busy      = r_busy;
   assign chi       = r_chi;
   assign chi_idx   = r_chi_idx;
   assign chi_valid = r_chi_valid;

endmodule

// File: tb/tb_sigma_point_gen.sv
// tb_sigma_point_gen: three instances (GAMMA default, 1.0, 2.0) on shared
// stimulus; points are checked against an arithmetic reference model.
module tb_sigma_point_gen;

   localparam int N  = 5;
   localparam int W  = 32;
   localparam int NL = 15;
   localparam int NW = W*N;

   logic            clk = 1'b0;
   logic            clk_en;
   logic            rst;
   logic [NL*W-1:0] L;
   logic            L_valid;
   logic [NW-1:0]   x_mean;
   logic            chi_ready;

   logic            busy0, busy1, busy2;
   logic [NW-1:0]   chi0, chi1, chi2;
   logic [3:0]      idx0, idx1, idx2;
   logic            val0, val1, val2;

   logic            busy_s;
   logic [NW-1:0]   chi_s;
   logic [3:0]      chi_idx_s;
   logic            chi_valid_s;

   int              sel;
   int              errors = 0;
   int              checks = 0;
   logic [W-1:0]    gam [3];
   logic [W-1:0]    mL [NL];
   logic [W-1:0]    mX [N];
   logic [NW-1:0]   got_c [11];
   logic [3:0]      got_i [11];
   int              got_n;

   always #5 clk = ~clk;

   sigma_point_gen u_dut0 (
      .clk(clk), .clk_en(clk_en), .rst(rst), .L(L), .L_valid(L_valid),
      .x_mean(x_mean), .busy(busy0), .chi(chi0), .chi_idx(idx0),
      .chi_valid(val0), .chi_ready(chi_ready));

   sigma_point_gen #(.GAMMA(32'h00010000)) u_dut1 (
      .clk(clk), .clk_en(clk_en), .rst(rst), .L(L), .L_valid(L_valid),
      .x_mean(x_mean), .busy(busy1), .chi(chi1), .chi_idx(idx1),
      .chi_valid(val1), .chi_ready(chi_ready));

   sigma_point_gen #(.GAMMA(32'h00020000)) u_dut2 (
      .clk(clk), .clk_en(clk_en), .rst(rst), .L(L), .L_valid(L_valid),
      .x_mean(x_mean), .busy(busy2), .chi(chi2), .chi_idx(idx2),
      .chi_valid(val2), .chi_ready(chi_ready));

   always_comb begin
      case (sel)
         1: begin
            busy_s = busy1; chi_s = chi1; chi_idx_s = idx1; chi_valid_s = val1;
         end
         2: begin
            busy_s = busy2; chi_s = chi2; chi_idx_s = idx2; chi_valid_s = val2;
         end
         default: begin
            busy_s = busy0; chi_s = chi0; chi_idx_s = idx0; chi_valid_s = val0;
         end
      endcase
   end

   function automatic logic [W-1:0] sat32(input longint v);
      logic [W-1:0] r;
      if (v > 64'sh7FFFFFFF)
         r = 32'h7FFFFFFF;
      else if (v < -64'sh80000000)
         r = 32'h80000000;
      else
         r = v[31:0];
      return r;
   endfunction

   // Reference: chi_idx -> column and sign, s = sat(floor(L*G/2^16))
   function automatic logic [NW-1:0] exp_pt(input int idx);
      logic [NW-1:0] r;
      longint xv, sv, g;
      int j;
      r = '0;
      g = longint'($signed(gam[sel]));
      j = (idx <= N) ? idx - 1 : idx - N - 1;
      for (int i = 0; i < N; i++) begin
         xv = longint'($signed(mX[i]));
         sv = 0;
         if (idx > 0 && i >= j)
            sv = longint'($signed(sat32(
                    (longint'($signed(mL[i*(i+1)/2 + j])) * g) >>> 16)));
         if (idx > N)
            r[W*i +: W] = sat32(xv - sv);
         else
            r[W*i +: W] = sat32(xv + sv);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      case ($urandom_range(0, 4))
         0: v = $urandom();
         1: v = 32'($urandom_range(0, 32'h001FFFFF)) - 32'h00100000;
         2: v = 32'h7FF00000 | 32'($urandom_range(0, 32'h000FFFFF));
         3: v = 32'h80000000 | 32'($urandom_range(0, 32'h000FFFFF));
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic rand_data(output logic [NL*W-1:0] l,
                            output logic [NW-1:0] x);
      for (int k = 0; k < NL; k++) l[W*k +: W] = rand_word();
      for (int i = 0; i < N; i++) x[W*i +: W] = rand_word();
   endtask

   // Present one L_valid beat and record it as the model's operands
   task automatic start(input logic [NL*W-1:0] l, input logic [NW-1:0] x);
      L = l;
      x_mean = x;
      L_valid = 1'b1;
      for (int k = 0; k < NL; k++) mL[k] = l[W*k +: W];
      for (int i = 0; i < N; i++) mX[i] = x[W*i +: W];
      @(posedge clk); #1;
      L_valid = 1'b0;
   endtask

   task automatic get_beat(input int mode, output bit ok,
                           output logic [NW-1:0] c, output logic [3:0] ix);
      ok = 1'b0;
      c = '0;
      ix = '0;
      for (int n = 0; n < 200 && !ok; n++) begin
         if (mode == 0) chi_ready = 1'b1;
         else if (mode == 1) chi_ready = ~chi_ready;
         else chi_ready = 1'($urandom_range(0, 1));
         if (chi_valid_s === 1'b1 && chi_ready) begin
            c = chi_s;
            ix = chi_idx_s;
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic collect(input int mode);
      bit ok;
      logic [NW-1:0] c;
      logic [3:0] ix;
      got_n = 0;
      for (int b = 0; b < 11; b++) begin
         got_c[b] = '0;
         got_i[b] = 4'hF;
      end
      for (int b = 0; b < 11; b++) begin
         get_beat(mode, ok, c, ix);
         if (!ok) break;
         got_c[b] = c;
         got_i[b] = ix;
         got_n++;
      end
      chi_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clk_en = 1'b1; L_valid = 1'b0; chi_ready = 1'b0;
      L = '0; x_mean = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         checks++;
         if (busy_s !== 1'b0 || chi_valid_s !== 1'b0 ||
             chi_idx_s !== 4'd0 || chi_s !== '0) begin
            errors++;
            $display("FAIL reset_u%0d: busy=%b valid=%b idx=%0d chi=%h, required all 0",
                     s, busy_s, chi_valid_s, chi_idx_s, chi_s);
         end
      end
   endtask

   task automatic test_gamma_one();
      logic [NL*W-1:0] a;
      logic [NW-1:0] e1, e2, e5, e6;
      a = 480'h000a0000_00000000_00140000_00070000_00020000_00c80000_001e0000_00060000_00000000_00640000_00000000_00120000_00320000_00090000_00190000;
      e1 = {32'h00020000, 32'h00000000, 32'h00120000, 32'h00090000, 32'h00190000};
      e2 = {32'h00070000, 32'h00060000, 32'h00000000, 32'h00320000, 32'h00000000};
      e5 = {32'h000A0000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
      e6 = {32'hFFFE0000, 32'h00000000, 32'hFFEE0000, 32'hFFF70000, 32'hFFE70000};
      sel = 1;
      start(a, '0);
      collect(0);
      checks++;
      if (got_n !== 11) begin
         errors++;
         $display("FAIL g1_count: beats=%0d, required 11", got_n);
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (got_i[b] !== 4'(b) || got_c[b] !== exp_pt(b)) begin
            errors++;
            $display("FAIL g1_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                     b, got_i[b], got_c[b], b, exp_pt(b));
         end
      end
      checks++;
      if (got_c[1] !== e1 || got_c[2] !== e2 || got_c[5] !== e5 || got_c[6] !== e6) begin
         errors++;
         $display("FAIL g1_vectors: chi1=%h chi2=%h chi5=%h chi6=%h, required %h %h %h %h",
                  got_c[1], got_c[2], got_c[5], got_c[6], e1, e2, e5, e6);
      end
   endtask

   task automatic test_gamma_two();
      logic [NL*W-1:0] a;
      logic [NW-1:0] x1, e5, e10;
      int first;
      a = 480'h000a0000_00000000_00140000_00070000_00020000_00c80000_001e0000_00060000_00000000_00640000_00000000_00120000_00320000_00090000_00190000;
      x1 = {5{32'h00010000}};
      e5 = {32'h00150000, {4{32'h00010000}}};
      e10 = {32'hFFED0000, {4{32'h00010000}}};
      sel = 2;
      chi_ready = 1'b0;
      start(a, x1);
      checks++;
      if (busy_s !== 1'b1 || chi_valid_s !== 1'b0) begin
         errors++;
         $display("FAIL g2_busy: busy=%b valid=%b, required 1 0", busy_s, chi_valid_s);
      end
      first = -1;
      for (int n = 1; n <= 40 && first < 0; n++) begin
         @(posedge clk); #1;
         if (chi_valid_s === 1'b1) first = n;
      end
      checks++;
      if (first != 16) begin
         errors++;
         $display("FAIL g2_latency: first valid at %0d, required 16", first);
      end
      collect(0);
      checks++;
      if (got_n !== 11 || got_c[0] !== x1 || got_c[5] !== e5 || got_c[10] !== e10) begin
         errors++;
         $display("FAIL g2_vectors: n=%0d chi0=%h chi5=%h chi10=%h, required 11 %h %h %h",
                  got_n, got_c[0], got_c[5], got_c[10], x1, e5, e10);
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (got_i[b] !== 4'(b) || got_c[b] !== exp_pt(b)) begin
            errors++;
            $display("FAIL g2_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                     b, got_i[b], got_c[b], b, exp_pt(b));
         end
      end
   endtask

   task automatic test_saturation();
      logic [NL*W-1:0] l;
      logic [NW-1:0] x;
      l = '0;
      l[31:0] = 32'h000A0000;
      x = '0;
      x[31:0] = 32'h7FFF0000;
      sel = 0;
      start(l, x);
      collect(0);
      checks++;
      if (got_n !== 11 || got_c[1][31:0] !== 32'h7FFFFFFF ||
          got_c[6][31:0] !== 32'h7FE8A3A0) begin
         errors++;
         $display("FAIL sat_elem0: n=%0d chi1[0]=%h chi6[0]=%h, required 11 7fffffff 7fe8a3a0",
                  got_n, got_c[1][31:0], got_c[6][31:0]);
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (got_i[b] !== 4'(b) || got_c[b] !== exp_pt(b)) begin
            errors++;
            $display("FAIL sat_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                     b, got_i[b], got_c[b], b, exp_pt(b));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [NL*W-1:0] l;
      logic [NW-1:0] x, hchi;
      int nb, hold;
      sel = 0;
      rand_data(l, x);
      start(l, x);
      chi_ready = 1'b1;
      nb = 0;
      hold = 0;
      hchi = '0;
      for (int c = 0; c < 300 && nb < 11; c++) begin
         if (chi_valid_s === 1'b1) begin
            if (chi_idx_s == 4'd3 && hold < 3) begin
               if (hold == 0) begin
                  hchi = chi_s;
               end else begin
                  checks++;
                  if (chi_s !== hchi || chi_idx_s !== 4'd3) begin
                     errors++;
                     $display("FAIL bp_hold%0d: idx=%0d chi=%h, required idx=3 chi=%h",
                              hold, chi_idx_s, chi_s, hchi);
                  end
               end
               hold++;
               chi_ready = 1'b0;
            end else begin
               chi_ready = 1'b1;
               checks++;
               if (chi_idx_s !== 4'(nb) || chi_s !== exp_pt(nb)) begin
                  errors++;
                  $display("FAIL bp_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                           nb, chi_idx_s, chi_s, nb, exp_pt(nb));
               end
               nb++;
            end
         end
         @(posedge clk); #1;
      end
      chi_ready = 1'b0;
      checks++;
      if (nb != 11 || hold != 3 || chi_valid_s !== 1'b0 || busy_s !== 1'b0) begin
         errors++;
         $display("FAIL bp_end: beats=%0d stalls=%0d valid=%b busy=%b, required 11 3 0 0",
                  nb, hold, chi_valid_s, busy_s);
      end
      sel = $urandom_range(0, 2);
      rand_data(l, x);
      start(l, x);
      collect(1);
      checks++;
      if (got_n !== 11) begin
         errors++;
         $display("FAIL bp_toggle_count: beats=%0d, required 11", got_n);
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (got_i[b] !== 4'(b) || got_c[b] !== exp_pt(b)) begin
            errors++;
            $display("FAIL bp_toggle_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                     b, got_i[b], got_c[b], b, exp_pt(b));
         end
      end
   endtask

   task automatic test_ignore_lvalid();
      logic [NL*W-1:0] la, lb;
      logic [NW-1:0] xa, xb;
      sel = 0;
      rand_data(la, xa);
      rand_data(lb, xb);
      lb[31:0] = la[31:0] ^ 32'h00010000;
      start(la, xa);
      repeat (4) @(posedge clk);
      #1;
      L = lb;
      x_mean = xb;
      L_valid = 1'b1;
      @(posedge clk); #1;
      L_valid = 1'b0;
      got_n = 0;
      for (int b = 0; b < 11; b++) got_i[b] = 4'hF;
      for (int c = 0; c < 200 && got_n < 11; c++) begin
         chi_ready = 1'b1;
         L_valid = (got_n == 5);
         if (chi_valid_s === 1'b1) begin
            got_c[got_n] = chi_s;
            got_i[got_n] = chi_idx_s;
            got_n++;
         end
         @(posedge clk); #1;
      end
      L_valid = 1'b0;
      chi_ready = 1'b0;
      checks++;
      if (got_n !== 11 || busy_s !== 1'b0 || chi_valid_s !== 1'b0) begin
         errors++;
         $display("FAIL ign_end: beats=%0d busy=%b valid=%b, required 11 0 0",
                  got_n, busy_s, chi_valid_s);
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (got_i[b] !== 4'(b) || got_c[b] !== exp_pt(b)) begin
            errors++;
            $display("FAIL ign_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                     b, got_i[b], got_c[b], b, exp_pt(b));
         end
      end
      start(lb, xb);
      collect(0);
      checks++;
      if (got_n !== 11) begin
         errors++;
         $display("FAIL ign_next_count: beats=%0d, required 11", got_n);
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (got_i[b] !== 4'(b) || got_c[b] !== exp_pt(b)) begin
            errors++;
            $display("FAIL ign_next_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                     b, got_i[b], got_c[b], b, exp_pt(b));
         end
      end
   endtask

   task automatic test_reset_clken();
      logic [NL*W-1:0] l;
      logic [NW-1:0] x;
      int seen, first;
      sel = 0;
      rand_data(l, x);
      start(l, x);
      chi_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 60 && seen == 0; c++) begin
         if (chi_valid_s === 1'b1 && chi_idx_s == 4'd4) seen = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      rst = 1'b1;
      clk_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      clk_en = 1'b1;
      chi_ready = 1'b0;
      checks++;
      if (seen != 1 || busy_s !== 1'b0 || chi_valid_s !== 1'b0 ||
          chi_idx_s !== 4'd0 || chi_s !== '0) begin
         errors++;
         $display("FAIL rst_emit: seen=%0d busy=%b valid=%b idx=%0d chi=%h, required 1 and all 0",
                  seen, busy_s, chi_valid_s, chi_idx_s, chi_s);
      end
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (chi_valid_s !== 1'b0 || busy_s !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_quiet: %0d active cycles after reset, required 0", seen);
      end
      sel = $urandom_range(0, 2);
      rand_data(l, x);
      start(l, x);
      first = -1;
      for (int n = 1; n <= 60 && first < 0; n++) begin
         clk_en = (n >= 3 && n < 8) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         if (chi_valid_s === 1'b1) first = n;
      end
      clk_en = 1'b1;
      checks++;
      if (first != 21) begin
         errors++;
         $display("FAIL clken_latency: first valid at %0d, required 21", first);
      end
      collect(2);
      checks++;
      if (got_n !== 11) begin
         errors++;
         $display("FAIL clken_count: beats=%0d, required 11", got_n);
      end
      for (int b = 0; b < 11; b++) begin
         checks++;
         if (got_i[b] !== 4'(b) || got_c[b] !== exp_pt(b)) begin
            errors++;
            $display("FAIL clken_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                     b, got_i[b], got_c[b], b, exp_pt(b));
         end
      end
   endtask

   task automatic test_random();
      logic [NL*W-1:0] l;
      logic [NW-1:0] x;
      for (int r = 0; r < 6; r++) begin
         sel = $urandom_range(0, 2);
         rand_data(l, x);
         start(l, x);
         collect(2);
         checks++;
         if (got_n !== 11) begin
            errors++;
            $display("FAIL rnd%0d_count: beats=%0d, required 11", r, got_n);
         end
         for (int b = 0; b < 11; b++) begin
            checks++;
            if (got_i[b] !== 4'(b) || got_c[b] !== exp_pt(b)) begin
               errors++;
               $display("FAIL rnd%0d_beat%0d: idx=%0d chi=%h, required idx=%0d chi=%h",
                        r, b, got_i[b], got_c[b], b, exp_pt(b));
            end
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      gam[0] = 32'h00023C70;
      gam[1] = 32'h00010000;
      gam[2] = 32'h00020000;
      sel = 0;
      test_reset();
      test_gamma_one();
      test_gamma_two();
      test_saturation();
      test_backpressure();
      test_ignore_lvalid();
      test_reset_clken();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
